// File: rtl/kmeans_k3n4_ctrl.sv
// Iteration sequencer for the K=3, N=4 k-means datapath: streams sample addresses,
// drains the accumulate pipeline, handshakes with the centroid-update unit, repeats.
module kmeans_k3n4_ctrl #(
    parameter int input_data_qty_bit_width = 8,
    parameter int input_data_qty           = 256,
    parameter int pipe_latency             = 6,
    parameter int max_iter                 = 16,
    parameter int iter_bit_width           = 5
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                start_i,
    input  logic                                dp_ready_i,
    input  logic                                upd_ack_i,
    input  logic                                converged_i,
    output logic                                mem_rd_en_o,
    output logic [input_data_qty_bit_width-1:0] mem_rd_addr_o,
    output logic                                data_valid_o,
    output logic                                k_load_init_o,
    output logic                                acc_clear_o,
    output logic                                upd_req_o,
    output logic                                busy_o,
    output logic                                done_o,
    output logic [iter_bit_width-1:0]           iter_count_o
);

    localparam int AW = input_data_qty_bit_width;
    localparam int IW = iter_bit_width;
    localparam int DW = (pipe_latency > 0) ? $clog2(pipe_latency + 1) : 1;
    localparam logic [AW-1:0] ADDR_LAST  = AW'(input_data_qty - 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(pipe_latency);
    localparam logic [IW-1:0] ITER_MAX   = IW'(max_iter);

    typedef enum logic [2:0] {
        IDLE, INIT, STREAM, DRAIN, UPDATE, CHECK, DONE
    } state_e;

    state_e        state_q;
    logic [AW-1:0] addr_q;
    logic [AW-1:0] addr_d;
    logic [DW-1:0] drain_q;
    logic [IW-1:0] iter_q;
    logic [IW-1:0] iter_d;
    logic          last_pass_d;
    logic          last_pass_q;
    logic          data_valid_q;
    logic          k_load_init_q;
    logic          acc_clear_q;
    logic          upd_req_q;
    logic          busy_q;
    logic          done_q;

    // The read strobe follows dp_ready in the same cycle so a stalled datapath
    // never receives a sample it cannot take.
    assign mem_rd_en_o = (state_q == STREAM) && dp_ready_i;

    assign addr_d      = (addr_q == ADDR_LAST) ? '0 : addr_q + 1'b1;
    assign iter_d      = (iter_q == '1) ? iter_q : iter_q + 1'b1;
    assign last_pass_d = converged_i || (iter_d == ITER_MAX);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            drain_q       <= '0;
            iter_q        <= '0;
            last_pass_q   <= 1'b0;
            data_valid_q  <= 1'b0;
            k_load_init_q <= 1'b0;
            acc_clear_q   <= 1'b0;
            upd_req_q     <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            data_valid_q  <= mem_rd_en_o;
            k_load_init_q <= 1'b0;
            acc_clear_q   <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (start_i) begin
                        state_q       <= INIT;
                        k_load_init_q <= 1'b1;
                        acc_clear_q   <= 1'b1;
                        addr_q        <= '0;
                        drain_q       <= '0;
                        iter_q        <= '0;
                        busy_q        <= 1'b1;
                        done_q        <= 1'b0;
                    end
                end
                INIT: begin
                    state_q <= STREAM;
                end
                STREAM: begin
                    if (mem_rd_en_o) begin
                        addr_q <= addr_d;
                        if (addr_q == ADDR_LAST) begin
                            state_q <= DRAIN;
                            drain_q <= '0;
                        end
                    end
                end
                DRAIN: begin
                    // pipe_latency+1 cycles so the last data_valid is fully absorbed
                    if (drain_q == DRAIN_LAST) begin
                        state_q   <= UPDATE;
                        drain_q   <= '0;
                        upd_req_q <= 1'b1;
                    end else begin
                        drain_q <= drain_q + 1'b1;
                    end
                end
                UPDATE: begin
                    if (upd_ack_i) begin
                        state_q     <= CHECK;
                        upd_req_q   <= 1'b0;
                        iter_q      <= iter_d;
                        last_pass_q <= last_pass_d;
                        acc_clear_q <= !last_pass_d;
                    end
                end
                CHECK: begin
                    if (last_pass_q) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= STREAM;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    upd_req_q <= 1'b0;
                    busy_q    <= 1'b0;
                    done_q    <= 1'b0;
                end
            endcase
        end
    end

    assign mem_rd_addr_o = addr_q;
    assign data_valid_o  = data_valid_q;
    assign k_load_init_o = k_load_init_q;
    assign acc_clear_o   = acc_clear_q;
    assign upd_req_o     = upd_req_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign iter_count_o  = iter_q;

endmodule

// File: tb/tb_kmeans_k3n4_ctrl.sv
// Bench for kmeans_k3n4_ctrl: a per-run timeline model built from the pass arithmetic
// (reads on ready cycles, drain, update handshake, check) is compared cycle by cycle.
module tb_kmeans_k3n4_ctrl;

    localparam int AW   = 8;
    localparam int QTY  = 256;
    localparam int PL   = 6;
    localparam int MI   = 16;
    localparam int IW   = 5;
    localparam int MAXO = 8192;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic start = 1'b0, dp_ready = 1'b0, upd_ack = 1'b0, converged = 1'b0, sel = 1'b0;
    logic start_a, start_b;
    assign start_a = start & ~sel;
    assign start_b = start & sel;

    logic a_rd, a_dv, a_kl, a_ac, a_req, a_busy, a_done;
    logic b_rd, b_dv, b_kl, b_ac, b_req, b_busy, b_done;
    logic [AW-1:0] a_addr, b_addr;
    logic [IW-1:0] a_iter, b_iter;

    kmeans_k3n4_ctrl #(.input_data_qty_bit_width(AW), .input_data_qty(QTY),
                       .pipe_latency(PL), .max_iter(MI), .iter_bit_width(IW)) dut_a (
        .clk_i(clk), .rst_i(rst_n), .start_i(start_a), .dp_ready_i(dp_ready),
        .upd_ack_i(upd_ack), .converged_i(converged), .mem_rd_en_o(a_rd),
        .mem_rd_addr_o(a_addr), .data_valid_o(a_dv), .k_load_init_o(a_kl),
        .acc_clear_o(a_ac), .upd_req_o(a_req), .busy_o(a_busy), .done_o(a_done),
        .iter_count_o(a_iter));

    kmeans_k3n4_ctrl #(.input_data_qty_bit_width(AW), .input_data_qty(1),
                       .pipe_latency(PL), .max_iter(MI), .iter_bit_width(IW)) dut_b (
        .clk_i(clk), .rst_i(rst_n), .start_i(start_b), .dp_ready_i(dp_ready),
        .upd_ack_i(upd_ack), .converged_i(converged), .mem_rd_en_o(b_rd),
        .mem_rd_addr_o(b_addr), .data_valid_o(b_dv), .k_load_init_o(b_kl),
        .acc_clear_o(b_ac), .upd_req_o(b_req), .busy_o(b_busy), .done_o(b_done),
        .iter_count_o(b_iter));

    logic o_rd, o_dv, o_kl, o_ac, o_req, o_busy, o_done;
    logic [AW-1:0] o_addr;
    logic [IW-1:0] o_iter;
    assign o_rd   = sel ? b_rd   : a_rd;
    assign o_dv   = sel ? b_dv   : a_dv;
    assign o_kl   = sel ? b_kl   : a_kl;
    assign o_ac   = sel ? b_ac   : a_ac;
    assign o_req  = sel ? b_req  : a_req;
    assign o_busy = sel ? b_busy : a_busy;
    assign o_done = sel ? b_done : a_done;
    assign o_addr = sel ? b_addr : a_addr;
    assign o_iter = sel ? b_iter : a_iter;

    int n_chk = 0;
    int n_fail = 0;
    int cur_off = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s off=%0d got=%0d want=%0d", tag, cur_off, act, exp);
        end
    endtask

    // Stimulus and expectation tables, indexed by cycle offset from the start pulse.
    bit s_start[MAXO], s_rdy[MAXO], s_ack[MAXO], s_conv[MAXO];
    bit e_rd[MAXO], e_dv[MAXO], e_kl[MAXO], e_ac[MAXO], e_req[MAXO];
    bit e_busy[MAXO], e_done[MAXO], e_achk[MAXO];
    int e_addr[MAXO], e_iter[MAXO];

    task automatic check_all_zero(input string tag);
        chk({tag, "_rd_en"}, 32'(o_rd), 0);
        chk({tag, "_addr"}, 32'(o_addr), 0);
        chk({tag, "_data_valid"}, 32'(o_dv), 0);
        chk({tag, "_k_load_init"}, 32'(o_kl), 0);
        chk({tag, "_acc_clear"}, 32'(o_ac), 0);
        chk({tag, "_upd_req"}, 32'(o_req), 0);
        chk({tag, "_busy"}, 32'(o_busy), 0);
        chk({tag, "_done"}, 32'(o_done), 0);
        chk({tag, "_iter"}, 32'(o_iter), 0);
    endtask

    // rmode: 0 ready always, 1 ready on odd offsets, 2 random ready.
    // cpass: pass on which converged is reported (0 = never).
    task automatic run(input bit b, input int rmode, input int dly, input int cpass,
                       input bit stray, input bit bstart, input int abort_idx);
        int qty, c, u0, last_off, end_off, abort_off, it;
        int n_rd_exp, n_ac_exp, n_rd_obs, n_ac_obs;
        bit fin;
        qty = b ? 1 : QTY;
        for (int k = 0; k < MAXO; k++) begin
            s_start[k] = 1'b0;
            s_rdy[k]   = (rmode == 0) ? 1'b1 : (rmode == 1) ? (k % 2 == 1)
                                             : ($urandom_range(0, 1) == 1);
            s_ack[k]   = 1'b0;
            s_conv[k]  = ($urandom_range(0, 1) == 1);
            e_rd[k] = 0; e_dv[k] = 0; e_kl[k] = 0; e_ac[k] = 0; e_req[k] = 0;
            e_busy[k] = 0; e_done[k] = 0; e_achk[k] = 0; e_addr[k] = 0; e_iter[k] = 0;
        end
        s_start[0] = 1'b1;
        e_kl[1] = 1; e_ac[1] = 1; e_achk[1] = 1; e_addr[1] = 0;
        c = 2; fin = 0; abort_off = -1; last_off = 0; n_rd_exp = 0; n_ac_exp = 1;
        for (int p = 1; p <= MI && !fin; p++) begin
            for (int i = 0; i < qty; i++) begin
                while (!s_rdy[c] && c < MAXO - 64) c++;
                e_rd[c] = 1; e_achk[c] = 1; e_addr[c] = i; e_dv[c + 1] = 1;
                n_rd_exp++;
                if (p == 1 && i == abort_idx) abort_off = c;
                if (stray && $urandom_range(0, 7) == 0) s_ack[c] = 1'b1;
                c++;
            end
            u0 = c + PL + 1;
            for (int d = 0; d < dly; d++) e_req[u0 + d] = 1;
            s_ack[u0 + dly - 1]  = 1'b1;
            s_conv[u0 + dly - 1] = (p == cpass);
            c = u0 + dly;
            e_iter[c] = p;
            if (p == cpass || p == MI) begin
                fin = 1;
                last_off = c;
            end else begin
                e_ac[c] = 1;
                n_ac_exp++;
                c++;
            end
        end
        it = 0;
        for (int k = 1; k < MAXO; k++) begin
            if (e_iter[k] != 0) it = e_iter[k];
            e_iter[k] = it;
            e_busy[k] = (k <= last_off);
            e_done[k] = (k > last_off);
            if (bstart && k <= last_off) s_start[k] = ($urandom_range(0, 15) == 0);
        end
        end_off = last_off + 3;

        sel = b; n_rd_obs = 0; n_ac_obs = 0;
        for (int k = 0; k <= end_off; k++) begin
            @(posedge clk);
            #1;
            start = s_start[k]; dp_ready = s_rdy[k];
            upd_ack = s_ack[k]; converged = s_conv[k];
            @(negedge clk);
            cur_off = k;
            if (k >= 1) begin
                chk("rd_en", 32'(o_rd), 32'(e_rd[k]));
                chk("data_valid", 32'(o_dv), 32'(e_dv[k]));
                chk("k_load_init", 32'(o_kl), 32'(e_kl[k]));
                chk("acc_clear", 32'(o_ac), 32'(e_ac[k]));
                chk("upd_req", 32'(o_req), 32'(e_req[k]));
                chk("busy", 32'(o_busy), 32'(e_busy[k]));
                chk("done", 32'(o_done), 32'(e_done[k]));
                chk("iter_count", 32'(o_iter), 32'(e_iter[k]));
                if (e_achk[k]) chk("rd_addr", 32'(o_addr), 32'(e_addr[k]));
                n_rd_obs += int'(o_rd);
                n_ac_obs += int'(o_ac);
            end
            if (k == abort_off) begin
                #1 rst_n = 1'b0;
                #1 check_all_zero("async_rst");
                @(posedge clk);
                #1 start = 1'b0; dp_ready = 1'b0; upd_ack = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                @(negedge clk);
                check_all_zero("post_rst");
                return;
            end
        end
        start = 1'b0; upd_ack = 1'b0;
        chk("n_reads", 32'(n_rd_obs), 32'(n_rd_exp));
        chk("n_acc_clear", 32'(n_ac_obs), 32'(n_ac_exp));
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        // abort mid-stream when address 37 is being read
        run(1'b0, 0, 1, 1, 1'b0, 1'b0, 37);
        // single converged pass, back-to-back reads
        run(1'b0, 0, 1, 1, 1'b0, 1'b0, -1);
        // ready toggling every cycle
        run(1'b0, 1, 1, 1, 1'b0, 1'b0, -1);
        // never converges: runs to max_iter
        run(1'b0, 0, 1, 0, 1'b0, 1'b0, -1);
        // slow update ack, random ready, stray acks while streaming
        run(1'b0, 2, 10, 2, 1'b1, 1'b0, -1);
        // one sample per pass, start pulsed while busy, then restart from DONE
        run(1'b1, 2, 1, 0, 1'b1, 1'b1, -1);
        run(1'b1, 0, 3, 3, 1'b0, 1'b1, -1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
